// File: rtl/mmio_console_pkg.sv
// Shared definitions for the MMIO console responder: window addresses,
// default UART/FIFO sizing, FSM state encodings and the status register
// layout.
package mmio_console_pkg;

    localparam logic [31:0] MMIO_PUTC = 32'h8000_001C;
    localparam logic [31:0] MMIO_GETC = 32'h8000_0020;
    localparam logic [31:0] MMIO_STAT = 32'h8000_0024;
    localparam logic [31:0] MMIO_EXIT = 32'h8000_002C;

    localparam int unsigned MMIO_BAUD_DIV = 868;
    localparam int unsigned MMIO_TX_DEPTH = 16;

    // GETC value when no received byte is pending
    localparam logic [31:0] GETC_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Status register, bit 0 is rx_valid
    typedef struct packed {
        logic tx_ovr;
        logic frm_err;
        logic rx_ovr;
        logic tx_idle;
        logic tx_full;
        logic rx_valid;
    } stat_t;

endpackage

// File: rtl/console_fifo.sv
// Synchronous show-ahead FIFO for console TX bytes.
// Ports: clk, resetb (async active-low), push/wdata, pop/rdata_c (head
// entry, combinational), full/empty (registered).
// Pointers carry one extra wrap bit to tell full from empty.
module console_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even when a pop happens alongside
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        wr_ptr_nxt = wr_ptr + PW'(do_push);
        rd_ptr_nxt = rd_ptr + PW'(do_pop);
    end

    // Pointers and flags, flags derived from the next pointers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_console.sv
// MMIO console responder beside dmem: PUTC bytes go out a UART TX pin,
// UART RX bytes come back on GETC reads, EXIT writes are latched.
// Ports: clk, resetb (async active-low); dmem write port (wready, waddr,
// wdata, wstrb); dmem read port (rready, raddr -> rresp, rdata one cycle
// later); uart_tx/uart_rx; exit_valid/exit_code; rx_irq (= rx_valid).
// Build option: MMIO_CONSOLE_LOOPBACK_EN feeds the internal TX line into
// the RX synchronizer, ignores uart_rx and holds uart_tx high.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [31:0] PUTC_ADDR = MMIO_PUTC,
    parameter logic [31:0] GETC_ADDR = MMIO_GETC,
    parameter logic [31:0] EXIT_ADDR = MMIO_EXIT,
    parameter logic [31:0] STAT_ADDR = MMIO_STAT,
    parameter int unsigned BAUD_DIV  = MMIO_BAUD_DIV,
    parameter int unsigned TX_DEPTH  = MMIO_TX_DEPTH
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        dmem_wready,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        dmem_rready,
    input  logic [31:0] dmem_raddr,
    output logic        dmem_rresp,
    output logic [31:0] dmem_rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        rx_irq
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shreg;
    logic             tx_line;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shreg;
    logic             rx_in;
    logic             rx_s1, rx_s2, rx_s3;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ovr, frm_err, tx_ovr;

    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata_c;

    logic             putc_wr, exit_wr, getc_rd, stat_rd;
    logic             tx_pop, rx_pop, rx_ok, rx_err;
    stat_t            stat;
    logic [31:0]      rd_val;
    logic             unused_wstrb;

    assign unused_wstrb = ^dmem_wstrb[3:1];

    // Strobe decode and event terms shared by the FSMs and flags
    always_comb begin
        putc_wr = dmem_wready && (dmem_waddr == PUTC_ADDR) && dmem_wstrb[0];
        exit_wr = dmem_wready && (dmem_waddr == EXIT_ADDR);
        getc_rd = dmem_rready && (dmem_raddr == GETC_ADDR);
        stat_rd = dmem_rready && (dmem_raddr == STAT_ADDR);
        rx_pop  = getc_rd && rx_valid;
        // Pop from IDLE, or straight out of STOP so frames run back to back
        tx_pop  = !fifo_empty && ((tx_state == TX_IDLE) ||
                  ((tx_state == TX_STOP) && (tx_cnt == '0)));
        rx_ok   = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2;
        rx_err  = (rx_state == RX_STOP) && (rx_cnt == '0) && !rx_s2;
    end

    console_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push    (putc_wr),
        .wdata   (dmem_wdata[7:0]),
        .pop     (tx_pop),
        .rdata_c (fifo_rdata_c),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // TX FSM: 8N1, LSB first, each state held BAUD_DIV cycles
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shreg <= fifo_rdata_c;
                        tx_cnt   <= CNT_LAST;
                        tx_line  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= CNT_LAST;
                        tx_idx   <= '0;
                        tx_line  <= tx_shreg[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= CNT_LAST;
                        if (tx_idx == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_line  <= tx_shreg[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (tx_pop) begin
                            tx_shreg <= fifo_rdata_c;
                            tx_cnt   <= CNT_LAST;
                            tx_line  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef MMIO_CONSOLE_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = uart_rx;
    assign rx_in     = tx_line;
    assign uart_tx   = 1'b1;
`else
    assign rx_in     = uart_rx;
    assign uart_tx   = tx_line;
`endif

    // RX synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX FSM: start bit rechecked at mid-bit, then one sample per bit time
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= CNT_HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= CNT_LAST;
                            rx_idx   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_cnt   <= CNT_LAST;
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as the clearing read wins
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_ovr     <= 1'b0;
            frm_err    <= 1'b0;
            tx_ovr     <= 1'b0;
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else begin
            if (rx_ok) begin
                rx_byte <= rx_shreg;
            end
            rx_valid <= rx_ok || (rx_valid && !rx_pop);
            rx_ovr   <= (rx_ok && rx_valid && !rx_pop) || (rx_ovr && !stat_rd);
            frm_err  <= rx_err || (frm_err && !stat_rd);
            tx_ovr   <= (putc_wr && fifo_full) || (tx_ovr && !stat_rd);
            if (exit_wr) begin
                exit_valid <= 1'b1;
                if (!exit_valid) begin
                    exit_code <= dmem_wdata;
                end
            end
        end
    end

    // Read mux
    always_comb begin
        stat.tx_ovr   = tx_ovr;
        stat.frm_err  = frm_err;
        stat.rx_ovr   = rx_ovr;
        stat.tx_idle  = fifo_empty && (tx_state == TX_IDLE);
        stat.tx_full  = fifo_full;
        stat.rx_valid = rx_valid;
        rd_val        = '0;
        if (getc_rd) begin
            rd_val = rx_valid ? {24'h0, rx_byte} : GETC_EMPTY;
        end else if (stat_rd) begin
            rd_val = 32'(stat);
        end
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dmem_rresp <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_rresp <= dmem_rready;
            dmem_rdata <= dmem_rready ? rd_val : '0;
        end
    end

    assign rx_irq = rx_valid;

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console with BAUD_DIV=4, TX_DEPTH=16.
// Read results and transmitted bytes are checked against scoreboard
// queues filled as stimulus is driven. Define MMIO_CONSOLE_LOOPBACK_EN to
// exercise the loopback build instead of the pin-level tests.
module tb_mmio_console;
    import mmio_console_pkg::*;

    localparam int unsigned BD = 4;

    logic        clk = 1'b0;
    logic        resetb;
    logic        dmem_wready = 1'b0;
    logic [31:0] dmem_waddr  = '0;
    logic [31:0] dmem_wdata  = '0;
    logic [3:0]  dmem_wstrb  = '0;
    logic        dmem_rready = 1'b0;
    logic [31:0] dmem_raddr  = '0;
    logic        dmem_rresp;
    logic [31:0] dmem_rdata;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        rx_irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd[$];
    string       tag_rd[$];
    logic [7:0]  exp_tx[$];
    logic        tx_chk_en = 1'b1;

    mmio_console #(
        .BAUD_DIV (BD),
        .TX_DEPTH (16)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .dmem_wready (dmem_wready),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_rready (dmem_rready),
        .dmem_raddr  (dmem_raddr),
        .dmem_rresp  (dmem_rresp),
        .dmem_rdata  (dmem_rdata),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .exit_valid  (exit_valid),
        .exit_code   (exit_code),
        .rx_irq      (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
        dmem_wready = 1'b1;
        dmem_waddr  = addr;
        dmem_wdata  = data;
        dmem_wstrb  = 4'hF;
        cyc(1);
        dmem_wready = 1'b0;
    endtask

    task automatic putc(input logic [7:0] b, input logic expect_out);
        if (expect_out) exp_tx.push_back(b);
        mmio_write(MMIO_PUTC, {24'h0, b});
    endtask

    task automatic mmio_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        dmem_rready = 1'b1;
        dmem_raddr  = addr;
        exp_rd.push_back(exp);
        tag_rd.push_back(tag);
        cyc(1);
        dmem_rready = 1'b0;
        chk({tag, "_rresp"}, 32'(dmem_rresp), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        cyc(BD);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(BD);
        end
        uart_rx = stop_bit;
        cyc(BD);
        uart_rx = 1'b1;
        cyc(2 * BD);
    endtask

    // Read scoreboard: compare each response against the queued expectation
    always @(negedge clk) begin
        if (dmem_rresp === 1'b1) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk(tag_rd.pop_front(), dmem_rdata, exp_rd.pop_front());
        end
    end

    // TX line monitor: decode 8N1 frames at mid-bit and compare bytes
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (resetb === 1'b1 && uart_tx === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BD) @(negedge clk);
                if (tx_chk_en) begin
                    chk("tx_stop", 32'(uart_tx), 32'd1);
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'(b), 32'hFFFF);
                    else chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        logic [9:0] line;
        resetb = 1'b0;
        cyc(3);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_rresp", 32'(dmem_rresp), 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
        chk("rst_exit_valid", 32'(exit_valid), 32'd0);
        chk("rst_exit_code", exit_code, 32'd0);
        chk("rst_rx_irq", 32'(rx_irq), 32'd0);
        resetb = 1'b1;
        cyc(2);

`ifdef MMIO_CONSOLE_LOOPBACK_EN
        putc(8'hC3, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("lb_tx_high", 32'(uart_tx), 32'd1);
        end
        cyc(1);
        mmio_read(MMIO_GETC, 32'h0000_00C3, "lb_getc");
        mmio_read(MMIO_GETC, 32'hFFFF_FFFF, "lb_getc_empty");
        mmio_write(MMIO_EXIT, 32'h0000_0005);
        chk("lb_exit_valid", 32'(exit_valid), 32'd1);
        chk("lb_exit_code", exit_code, 32'd5);
`else
        // Single byte: exact line waveform, then idle status
        mmio_read(MMIO_STAT, 32'h0000_0004, "stat_idle0");
        putc(8'h41, 1'b1);
        @(negedge clk);
        chk("tx_before_start", 32'(uart_tx), 32'd1);
        line = 10'b10_1000_0010;
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            for (int c = 0; c < int'(BD); c++) begin
                @(negedge clk);
                chk($sformatf("tx41_bit%0d", bit_i), 32'(uart_tx), 32'(line[bit_i]));
            end
        end
        cyc(3);
        mmio_read(MMIO_STAT, 32'h0000_0004, "stat_idle1");

        // FIFO fill: 17 accepted (first pops at once), 18th dropped
        for (int i = 0; i < 17; i++) putc(8'h10 + 8'(i), 1'b1);
        putc(8'hEE, 1'b0);
        mmio_read(MMIO_STAT, 32'h0000_0022, "stat_full_ovr");
        mmio_read(MMIO_STAT, 32'h0000_0002, "stat_ovr_cleared");
        cyc(720);
        mmio_read(MMIO_STAT, 32'h0000_0004, "stat_drained");
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

        // RX single byte
        send_rx(8'h5A, 1'b1);
        chk("rx_irq_set", 32'(rx_irq), 32'd1);
        mmio_read(MMIO_GETC, 32'h0000_005A, "getc_5a");
        mmio_read(MMIO_GETC, 32'hFFFF_FFFF, "getc_empty");
        chk("rx_irq_clr", 32'(rx_irq), 32'd0);

        // Overrun, framing error, glitch
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        mmio_read(MMIO_STAT, 32'h0000_000D, "stat_rx_ovr");
        send_rx(8'h33, 1'b0);
        mmio_read(MMIO_STAT, 32'h0000_0015, "stat_frm_err");
        mmio_read(MMIO_GETC, 32'h0000_0022, "getc_second");
        uart_rx = 1'b0;
        cyc(1);
        uart_rx = 1'b1;
        cyc(12);
        chk("glitch_rx_irq", 32'(rx_irq), 32'd0);
        mmio_read(MMIO_STAT, 32'h0000_0004, "stat_glitch");
        mmio_read(MMIO_GETC, 32'hFFFF_FFFF, "getc_glitch");

        // Same-cycle write and read both take effect
        dmem_rready = 1'b1;
        dmem_raddr  = MMIO_STAT;
        exp_rd.push_back(32'h0000_0004);
        tag_rd.push_back("stat_with_write");
        mmio_write(MMIO_EXIT, 32'h0000_0003);
        dmem_rready = 1'b0;
        chk("exit_valid", 32'(exit_valid), 32'd1);
        mmio_write(MMIO_EXIT, 32'h0000_0007);
        chk("exit_code_first", exit_code, 32'd3);
        chk("exit_valid_hold", 32'(exit_valid), 32'd1);

        // Async reset in the middle of a frame
        tx_chk_en = 1'b0;
        putc(8'h00, 1'b0);
        cyc(10);
        chk("tx_mid_frame_low", 32'(uart_tx), 32'd0);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_uart_tx", 32'(uart_tx), 32'd1);
        chk("arst_exit_valid", 32'(exit_valid), 32'd0);
        chk("arst_exit_code", exit_code, 32'd0);
        cyc(3);
        resetb = 1'b1;
        cyc(2);
        mmio_read(MMIO_STAT, 32'h0000_0004, "stat_after_rst");
        chk("tx_after_rst", 32'(uart_tx), 32'd1);
`endif

        cyc(3);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
